wb_stage_multi: RTL and testbench
=================================

WB_STAGE_MULTI -- requirements
Module: wb_stage_multi

Interface
REQ-001 The block SHALL use one clock and a synchronous active-low reset, with ports clk and rst_n.
REQ-002 Parameter LANES, default 2, SHALL set the number of retire lanes; legal values are 1 and 2.
REQ-003 Parameter DW, default 32, SHALL set the data and PC width.
REQ-004 Ports (name  direction  width  meaning):
 clk  in  1  clock
 rst_n  in  1  synchronous active-low reset
 mem_valid_in  in  1  MEM offers a group
 wb_allowin_out  out  1  WB accepts the offered group this cycle
 mem_lane_valid_in  in  LANES  per-lane instruction valid
 mem_late_in  in  LANES  per-lane result arrives later via late_*
 mem_PC_in  in  LANES*DW  per-lane PC
 mem_wbdata_in  in  LANES*DW  per-lane writeback data
 mem_reg_we_in  in  LANES*4  per-lane byte write enables
 mem_wnum_in  in  LANES*5  per-lane destination register
 late_valid_in  in  1  late result beat
 late_data_in  in  DW  late result data
 wb_valid_out  out  1  group retires this cycle
 wb_reg_we_out  out  LANES*4  regfile byte write enables
 wb_wnum_out  out  LANES*5  regfile write numbers
 wb_wbdata_out  out  LANES*DW  regfile write data
 debug_wb_pc  out  DW  debug PC, one lane per beat
 debug_wb_rf_wen  out  4  debug write enable
 debug_wb_rf_wnum  out  5  debug write number
 debug_wb_rf_wdata  out  DW  debug write data

Function
REQ-005 A group SHALL be captured into the stage register on the edge where mem_valid_in and wb_allowin_out are both 1; all lane fields and mem_late_in SHALL be latched as pending bits.
REQ-006 The state machine SHALL have three states: EMPTY (no group), HOLD (group held), and DBG1 (second debug beat of a two-lane group).
REQ-007 Transitions: EMPTY->HOLD on capture; HOLD->EMPTY on retire when at most one lane is valid and nothing is captured; HOLD->HOLD on retire of a one-lane group with a new capture; HOLD->DBG1 on retire when both lanes are valid; DBG1->HOLD if a capture occurs, otherwise DBG1->EMPTY.
REQ-008 Retire SHALL occur in the first HOLD cycle with no pending late bits, so a group with no late lanes retires one cycle after capture.
REQ-009 late_valid_in SHALL be honoured only in HOLD with at least one pending late bit: it writes late_data_in into the lowest-index pending lane and clears that lane's bit; otherwise it is ignored.
REQ-010 A late beat and retire SHALL NOT occur in the same cycle; retire follows on the next cycle at the earliest.
REQ-011 wb_valid_out, wb_reg_we_out, wb_wnum_out and wb_wbdata_out SHALL be combinational from the stage register; they are asserted only in the retire cycle, and wb_reg_we_out is 0 in every other cycle.
REQ-012 Each lane's regfile write enable SHALL be its mem_reg_we_in, masked to 0 when the lane is invalid or its wnum is 0.
REQ-013 If both lanes write the same nonzero wnum, lane 0's write enable SHALL be forced to 0, so the younger lane 1 wins.
REQ-014 wb_allowin_out SHALL be 1 in EMPTY and DBG1, 1 in a HOLD retire cycle of a one-lane group, and 0 otherwise.
REQ-015 Debug outputs SHALL be registered. On the retire edge they load the lowest valid lane; on the DBG1 edge they load lane 1. debug_wb_rf_wen and debug_wb_rf_wnum use the masked values from REQ-012 but not the conflict mask from REQ-013.
REQ-016 On every other edge, debug_wb_rf_wen SHALL load 0, and debug_wb_pc, debug_wb_rf_wnum and debug_wb_rf_wdata SHALL hold their values.
REQ-017 Lane 1 data SHALL remain stable in the stage register until the DBG1 edge, even when a new group is captured on that same edge.
REQ-018 With LANES=1 the state DBG1 SHALL be unreachable.

Reset
REQ-019 While rst_n is 0 at a clock edge, the state SHALL become EMPTY, and all pending bits, stage valids and debug outputs SHALL become 0.
REQ-020 While rst_n is 0, wb_reg_we_out and wb_valid_out SHALL be forced to 0 combinationally; this holds for a reset applied mid-HOLD or mid-DBG1, and the group is discarded.
REQ-021 In the first cycle after reset deasserts, wb_allowin_out SHALL be 1.

Verification
REQ-022 One-lane group: lane 0 PC=0xBFC00000, wnum=3, we=0xF, data=0x12345678, late=0. Required: wb_valid_out=1 and wb_reg_we_out lane0=0xF in cycle capture+1, then debug_wb_pc=0xBFC00000 and debug_wb_rf_wen=0xF after the next edge.
REQ-023 Two-lane group with wnum 5 and 5: required lane0 we=0 and lane1 we=0xF in the retire cycle, wb_allowin_out=0 in the retire cycle, two debug beats (lane 0 PC then lane 1 PC), and wb_allowin_out=1 in DBG1.
REQ-024 Both lanes late: late beats carrying 0xAAAA0000 then 0xBBBB0000 land in lanes 0 and 1 respectively; retire comes one cycle after the second beat; a late_valid_in asserted in EMPTY is ignored.
REQ-025 Lane with wnum=0 and we=0xF: wb_reg_we_out for that lane is 0 and debug_wb_rf_wen is 0.
REQ-026 rst_n=0 in the cycle a group would retire: no regfile write, next state EMPTY, and all debug outputs 0.
REQ-027 Back-to-back one-lane groups arriving every cycle: each retires one cycle after capture, with no bubbles and wb_allowin_out held at 1.

Source files
------------

// File: rtl/wb_stage_multi_if.sv
// MEM->WB group handshake, late-result beat, regfile write port and debug trace.
interface wb_stage_multi_if #(
  parameter int LANES = 2,
  parameter int DW    = 32
);
  logic                     mem_valid_in;
  logic                     wb_allowin_out;
  logic [LANES-1:0]         mem_lane_valid_in;
  logic [LANES-1:0]         mem_late_in;
  logic [LANES-1:0][DW-1:0] mem_PC_in;
  logic [LANES-1:0][DW-1:0] mem_wbdata_in;
  logic [LANES-1:0][3:0]    mem_reg_we_in;
  logic [LANES-1:0][4:0]    mem_wnum_in;
  logic                     late_valid_in;
  logic [DW-1:0]            late_data_in;
  logic                     wb_valid_out;
  logic [LANES-1:0][3:0]    wb_reg_we_out;
  logic [LANES-1:0][4:0]    wb_wnum_out;
  logic [LANES-1:0][DW-1:0] wb_wbdata_out;
  logic [DW-1:0]            debug_wb_pc;
  logic [3:0]               debug_wb_rf_wen;
  logic [4:0]               debug_wb_rf_wnum;
  logic [DW-1:0]            debug_wb_rf_wdata;

  modport master (
    output mem_valid_in, mem_lane_valid_in, mem_late_in, mem_PC_in, mem_wbdata_in,
           mem_reg_we_in, mem_wnum_in, late_valid_in, late_data_in,
    input  wb_allowin_out, wb_valid_out, wb_reg_we_out, wb_wnum_out, wb_wbdata_out,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  mem_valid_in, mem_lane_valid_in, mem_late_in, mem_PC_in, mem_wbdata_in,
           mem_reg_we_in, mem_wnum_in, late_valid_in, late_data_in,
    output wb_allowin_out, wb_valid_out, wb_reg_we_out, wb_wnum_out, wb_wbdata_out,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_stage_multi.sv
// Writeback stage: holds one group of up to two lanes, fills late results in,
// retires to the regfile and replays each valid lane on the debug trace port.
module wb_lane (
  input  logic       vld,
  input  logic [3:0] we,
  input  logic [4:0] wnum,
  output logic [3:0] we_m
);
  // r0 is hardwired, so a write to it is no write at all
  assign we_m = (vld && wnum != 5'd0) ? we : 4'h0;
endmodule

module wb_stage_multi #(
  parameter int LANES = 2,
  parameter int DW    = 32
) (
  input logic             clk,
  input logic             rst_n,
  wb_stage_multi_if.slave bus
);
  localparam int L1 = LANES - 1;

  typedef enum logic [1:0] {EMPTY, HOLD, DBG1} st_t;
  st_t st;

  logic [LANES-1:0]         lane_vld, late_pend, late_hit;
  logic [LANES-1:0][DW-1:0] pc_q, data_q;
  logic [LANES-1:0][3:0]    we_q, we_m, we_rf;
  logic [LANES-1:0][4:0]    wnum_q;
  logic                     two_lane, retire, allowin, capture, late_ok;
  logic [DW-1:0]            sel_pc, sel_data;
  logic [3:0]               sel_we;
  logic [4:0]               sel_wnum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    wb_lane u_lane (.vld(lane_vld[i]), .we(we_q[i]), .wnum(wnum_q[i]), .we_m(we_m[i]));
  end

  // With one lane two_lane is constant 0, so DBG1 is never entered
  assign two_lane = (LANES == 2) && (&lane_vld);
  assign retire   = rst_n && (st == HOLD) && (late_pend == '0);
  assign allowin  = (st == EMPTY) || (st == DBG1) || (retire && !two_lane);
  assign capture  = bus.mem_valid_in && allowin;
  assign late_ok  = (st == HOLD) && (|late_pend) && bus.late_valid_in;
  assign late_hit = late_pend & (~late_pend + LANES'(1));

  // Same destination in both lanes: the younger lane 1 owns the write
  always_comb begin
    we_rf = we_m;
    if (LANES == 2 && (|we_m[0]) && (|we_m[L1]) && wnum_q[0] == wnum_q[L1])
      we_rf[0] = 4'h0;
  end

  always_comb begin
    sel_pc   = pc_q[0];
    sel_data = data_q[0];
    sel_we   = we_m[0];
    sel_wnum = wnum_q[0];
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_vld[i]) begin
        sel_pc   = pc_q[i];
        sel_data = data_q[i];
        sel_we   = we_m[i];
        sel_wnum = wnum_q[i];
      end
    end
  end

  assign bus.wb_allowin_out = allowin;
  assign bus.wb_valid_out   = retire;
  assign bus.wb_reg_we_out  = retire ? we_rf : '0;
  assign bus.wb_wnum_out    = wnum_q;
  assign bus.wb_wbdata_out  = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st                    <= EMPTY;
      lane_vld              <= '0;
      late_pend             <= '0;
      pc_q                  <= '0;
      data_q                <= '0;
      we_q                  <= '0;
      wnum_q                <= '0;
      bus.debug_wb_pc       <= '0;
      bus.debug_wb_rf_wen   <= '0;
      bus.debug_wb_rf_wnum  <= '0;
      bus.debug_wb_rf_wdata <= '0;
    end else begin
      case (st)
        EMPTY:   if (capture) st <= HOLD;
        HOLD:    if (retire) st <= two_lane ? DBG1 : (capture ? HOLD : EMPTY);
        DBG1:    st <= capture ? HOLD : EMPTY;
        default: st <= EMPTY;
      endcase

      // capture and a late beat never coincide: capture in HOLD needs no pending bits
      if (capture) begin
        lane_vld  <= bus.mem_lane_valid_in;
        late_pend <= bus.mem_late_in;
        pc_q      <= bus.mem_PC_in;
        data_q    <= bus.mem_wbdata_in;
        we_q      <= bus.mem_reg_we_in;
        wnum_q    <= bus.mem_wnum_in;
      end else if (late_ok) begin
        late_pend <= late_pend & ~late_hit;
        for (int i = 0; i < LANES; i++)
          if (late_hit[i]) data_q[i] <= bus.late_data_in;
      end

      // DBG1 reads the old lane 1 on the same edge a new group may overwrite it
      if (retire) begin
        bus.debug_wb_pc       <= sel_pc;
        bus.debug_wb_rf_wen   <= sel_we;
        bus.debug_wb_rf_wnum  <= sel_wnum;
        bus.debug_wb_rf_wdata <= sel_data;
      end else if (st == DBG1) begin
        bus.debug_wb_pc       <= pc_q[L1];
        bus.debug_wb_rf_wen   <= we_m[L1];
        bus.debug_wb_rf_wnum  <= wnum_q[L1];
        bus.debug_wb_rf_wdata <= data_q[L1];
      end else begin
        bus.debug_wb_rf_wen   <= 4'h0;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage_multi.sv
// Bench for wb_stage_multi (LANES=2, DW=32): directed vectors, corner sequences
// and a queue-based group/debug-beat reference model checked every cycle.
module tb_wb_stage_multi;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_stage_multi_if #(.LANES(2), .DW(32)) bus ();
  wb_stage_multi #(.LANES(2), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct packed {
    logic [1:0]       vld;
    logic [1:0]       pend;
    logic [1:0][31:0] pc;
    logic [1:0][31:0] data;
    logic [1:0][3:0]  we;
    logic [1:0][4:0]  wnum;
  } grp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    grp_t        g;
    logic [7:0]  ewe;
    logic        eallow;
    int          nb;
    logic [31:0] bpc0, bpc1;
    logic [3:0]  bw0, bw1;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic grp_t mkg(logic [1:0] vld, logic [1:0] late, logic [31:0] pc0, logic [31:0] pc1,
                               logic [4:0] wn0, logic [4:0] wn1, logic [3:0] we0, logic [3:0] we1,
                               logic [31:0] d0, logic [31:0] d1);
    grp_t g;
    g.vld = vld; g.pend = late;
    g.pc[0] = pc0; g.pc[1] = pc1;
    g.wnum[0] = wn0; g.wnum[1] = wn1;
    g.we[0] = we0; g.we[1] = we1;
    g.data[0] = d0; g.data[1] = d1;
    return g;
  endfunction

  // Regfile rule: invalid lane or r0 writes nothing; same register in both lanes -> lane 1 wins
  function automatic logic [7:0] exp_we(grp_t g);
    logic [1:0][3:0] m;
    for (int i = 0; i < 2; i++) m[i] = (g.vld[i] && g.wnum[i] != 5'd0) ? g.we[i] : 4'h0;
    if (m[0] != 4'h0 && m[1] != 4'h0 && g.wnum[0] == g.wnum[1]) m[0] = 4'h0;
    return m;
  endfunction

  function automatic beat_t mk_beat(grp_t g, int i);
    beat_t b;
    b.pc    = g.pc[i];
    b.wen   = (g.wnum[i] != 5'd0) ? g.we[i] : 4'h0;
    b.wnum  = g.wnum[i];
    b.wdata = g.data[i];
    return b;
  endfunction

  task automatic drive_grp(grp_t g);
    bus.mem_valid_in      = 1'b1;
    bus.mem_lane_valid_in = g.vld;
    bus.mem_late_in       = g.pend;
    bus.mem_PC_in         = g.pc;
    bus.mem_wbdata_in     = g.data;
    bus.mem_reg_we_in     = g.we;
    bus.mem_wnum_in       = g.wnum;
  endtask

  task automatic idle();
    bus.mem_valid_in  = 1'b0;
    bus.late_valid_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: at most one held group; every retired valid lane becomes one
  // debug beat, and the trace port emits one queued beat per clock edge.
  grp_t  mg;
  bit    held = 1'b0;
  beat_t exp_dbg = '0;
  beat_t dq[$];

  always @(negedge clk) begin
    bit ret, allow;
    int lo;
    if (mon_en) begin
      chk("m_dbg_pc", 64'(bus.debug_wb_pc), 64'(exp_dbg.pc));
      chk("m_dbg_wen", 64'(bus.debug_wb_rf_wen), 64'(exp_dbg.wen));
      chk("m_dbg_wnum", 64'(bus.debug_wb_rf_wnum), 64'(exp_dbg.wnum));
      chk("m_dbg_wdata", 64'(bus.debug_wb_rf_wdata), 64'(exp_dbg.wdata));
      if (!rst_n) begin
        chk("m_rst_valid", 64'(bus.wb_valid_out), 64'h0);
        chk("m_rst_we", 64'(bus.wb_reg_we_out), 64'h0);
        held = 1'b0;
        dq.delete();
        exp_dbg = '0;
      end else begin
        ret   = held && (mg.pend == 2'b00);
        allow = !held || (ret && mg.vld != 2'b11);
        chk("m_valid", 64'(bus.wb_valid_out), 64'(ret));
        chk("m_we", 64'(bus.wb_reg_we_out), ret ? 64'(exp_we(mg)) : 64'h0);
        chk("m_allowin", 64'(bus.wb_allowin_out), 64'(allow));
        if (ret) begin
          chk("m_wnum", 64'(bus.wb_wnum_out), 64'(mg.wnum));
          chk("m_wdata", 64'(bus.wb_wbdata_out), 64'(mg.data));
        end
        if (held && bus.late_valid_in && mg.pend != 2'b00) begin
          lo = mg.pend[0] ? 0 : 1;
          mg.data[lo] = bus.late_data_in;
          mg.pend[lo] = 1'b0;
        end
        if (ret) begin
          held = 1'b0;
          for (int i = 0; i < 2; i++) if (mg.vld[i]) dq.push_back(mk_beat(mg, i));
        end
        if (bus.mem_valid_in && allow) begin
          held = 1'b1;
          mg = mkg(bus.mem_lane_valid_in, bus.mem_late_in, bus.mem_PC_in[0], bus.mem_PC_in[1],
                   bus.mem_wnum_in[0], bus.mem_wnum_in[1], bus.mem_reg_we_in[0], bus.mem_reg_we_in[1],
                   bus.mem_wbdata_in[0], bus.mem_wbdata_in[1]);
        end
        if (dq.size() > 0) exp_dbg = dq.pop_front();
        else exp_dbg.wen = 4'h0;
      end
    end
  end

  vec_t vt[6];

  initial begin
    vt[0] = '{mkg(2'b01, 2'b00, 32'hBFC00000, 32'h0, 5'd3, 5'd7, 4'hF, 4'hF, 32'h12345678, 32'h0),
              8'h0F, 1'b1, 1, 32'hBFC00000, 32'h0, 4'hF, 4'h0};
    vt[1] = '{mkg(2'b11, 2'b00, 32'hBFC00010, 32'hBFC00014, 5'd5, 5'd5, 4'hF, 4'hF, 32'hA1, 32'hA2),
              8'hF0, 1'b0, 2, 32'hBFC00010, 32'hBFC00014, 4'hF, 4'hF};
    vt[2] = '{mkg(2'b01, 2'b00, 32'hBFC00020, 32'h0, 5'd0, 5'd0, 4'hF, 4'h0, 32'h55, 32'h0),
              8'h00, 1'b1, 1, 32'hBFC00020, 32'h0, 4'h0, 4'h0};
    vt[3] = '{mkg(2'b11, 2'b00, 32'hBFC00030, 32'hBFC00034, 5'd1, 5'd2, 4'h3, 4'hC, 32'hB1, 32'hB2),
              8'hC3, 1'b0, 2, 32'hBFC00030, 32'hBFC00034, 4'h3, 4'hC};
    vt[4] = '{mkg(2'b10, 2'b00, 32'hBFC00040, 32'hBFC00044, 5'd4, 5'd9, 4'hF, 4'hF, 32'hC1, 32'hC2),
              8'hF0, 1'b1, 1, 32'hBFC00044, 32'h0, 4'hF, 4'h0};
    vt[5] = '{mkg(2'b11, 2'b00, 32'hBFC00050, 32'hBFC00054, 5'd4, 5'd0, 4'hF, 4'hF, 32'hD1, 32'hD2),
              8'h0F, 1'b0, 2, 32'hBFC00050, 32'hBFC00054, 4'hF, 4'h0};

    rst_n = 1'b0;
    drive_grp(mkg(2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0, 32'h0));
    idle();
    bus.late_data_in = 32'h0;
    tick();
    tick();
    mon_en = 1'b1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_allowin", 64'(bus.wb_allowin_out), 64'h1);
    chk("rst_valid", 64'(bus.wb_valid_out), 64'h0);
    chk("rst_dbg_pc", 64'(bus.debug_wb_pc), 64'h0);
    chk("rst_dbg_wen", 64'(bus.debug_wb_rf_wen), 64'h0);
    tick();

    foreach (vt[k]) begin
      drive_grp(vt[k].g);
      @(negedge clk);
      chk($sformatf("v%0d_allow_cap", k), 64'(bus.wb_allowin_out), 64'h1);
      tick();
      idle();
      @(negedge clk);
      chk($sformatf("v%0d_valid", k), 64'(bus.wb_valid_out), 64'h1);
      chk($sformatf("v%0d_we", k), 64'(bus.wb_reg_we_out), 64'(vt[k].ewe));
      chk($sformatf("v%0d_allow_ret", k), 64'(bus.wb_allowin_out), 64'(vt[k].eallow));
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_b0_pc", k), 64'(bus.debug_wb_pc), 64'(vt[k].bpc0));
      chk($sformatf("v%0d_b0_wen", k), 64'(bus.debug_wb_rf_wen), 64'(vt[k].bw0));
      chk($sformatf("v%0d_we_idle", k), 64'(bus.wb_reg_we_out), 64'h0);
      if (vt[k].nb == 2) chk($sformatf("v%0d_allow_dbg1", k), 64'(bus.wb_allowin_out), 64'h1);
      tick();
      @(negedge clk);
      if (vt[k].nb == 2) begin
        chk($sformatf("v%0d_b1_pc", k), 64'(bus.debug_wb_pc), 64'(vt[k].bpc1));
        chk($sformatf("v%0d_b1_wen", k), 64'(bus.debug_wb_rf_wen), 64'(vt[k].bw1));
      end else begin
        chk($sformatf("v%0d_wen_off", k), 64'(bus.debug_wb_rf_wen), 64'h0);
      end
      tick();
    end

    // Both lanes late; a beat offered while empty must be dropped
    bus.late_valid_in = 1'b1;
    bus.late_data_in  = 32'hDEAD0000;
    @(negedge clk);
    chk("late_empty_valid", 64'(bus.wb_valid_out), 64'h0);
    tick();
    bus.late_valid_in = 1'b0;
    drive_grp(mkg(2'b11, 2'b11, 32'hBFC00100, 32'hBFC00104, 5'd1, 5'd2, 4'hF, 4'hF, 32'h11111111, 32'h22222222));
    tick();
    idle();
    bus.late_valid_in = 1'b1;
    bus.late_data_in  = 32'hAAAA0000;
    @(negedge clk);
    chk("late_beat1_valid", 64'(bus.wb_valid_out), 64'h0);
    chk("late_beat1_allow", 64'(bus.wb_allowin_out), 64'h0);
    tick();
    bus.late_data_in = 32'hBBBB0000;
    @(negedge clk);
    chk("late_beat2_valid", 64'(bus.wb_valid_out), 64'h0);
    tick();
    bus.late_valid_in = 1'b0;
    @(negedge clk);
    chk("late_ret_valid", 64'(bus.wb_valid_out), 64'h1);
    chk("late_ret_data", 64'(bus.wb_wbdata_out), {32'hBBBB0000, 32'hAAAA0000});
    chk("late_ret_we", 64'(bus.wb_reg_we_out), 64'hFF);
    tick();
    tick();
    tick();

    // Reset lands on the retire cycle: group discarded, trace cleared
    drive_grp(mkg(2'b01, 2'b00, 32'hBFC00200, 32'h0, 5'd6, 5'd0, 4'hF, 4'h0, 32'h66, 32'h0));
    tick();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstret_valid", 64'(bus.wb_valid_out), 64'h0);
    chk("rstret_we", 64'(bus.wb_reg_we_out), 64'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstret_valid_after", 64'(bus.wb_valid_out), 64'h0);
    chk("rstret_allow", 64'(bus.wb_allowin_out), 64'h1);
    chk("rstret_dbg", 64'({bus.debug_wb_pc, bus.debug_wb_rf_wen, bus.debug_wb_rf_wnum}), 64'h0);
    chk("rstret_dbg_wdata", 64'(bus.debug_wb_rf_wdata), 64'h0);
    tick();

    // Back-to-back single-lane groups, one per cycle
    for (int j = 0; j < 8; j++) begin
      drive_grp(mkg(2'b01, 2'b00, 32'hBFC00300 + 32'(4 * j), 32'h0, 5'(j + 1), 5'd0, 4'hF, 4'h0,
                    32'h100 + 32'(j), 32'h0));
      @(negedge clk);
      chk($sformatf("b2b%0d_allow", j), 64'(bus.wb_allowin_out), 64'h1);
      if (j > 0) begin
        chk($sformatf("b2b%0d_valid", j), 64'(bus.wb_valid_out), 64'h1);
        chk($sformatf("b2b%0d_data", j), 64'(bus.wb_wbdata_out[0]), 64'(32'h100 + 32'(j - 1)));
      end
      tick();
    end
    idle();
    @(negedge clk);
    chk("b2b_last_valid", 64'(bus.wb_valid_out), 64'h1);
    tick();

    // Randomized traffic against the reference model
    for (int c = 0; c < 2000; c++) begin
      rst_n                 = ($urandom_range(0, 199) != 0);
      bus.mem_valid_in      = 1'($urandom_range(0, 1));
      bus.mem_lane_valid_in = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        bus.mem_late_in[i]   = ($urandom_range(0, 3) == 0);
        bus.mem_PC_in[i]     = $urandom();
        bus.mem_wbdata_in[i] = $urandom();
        bus.mem_reg_we_in[i] = 4'($urandom_range(1, 15));
        bus.mem_wnum_in[i]   = 5'($urandom_range(0, 3));
      end
      bus.late_valid_in = 1'($urandom_range(0, 1));
      bus.late_data_in  = $urandom();
      tick();
    end
    rst_n = 1'b1;
    idle();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
